// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants and FSM state type for the 2048 board link
package game_pkg;

    localparam int BOARD_N = 4;
    localparam int CELLS   = BOARD_N * BOARD_N;
    localparam int CELL_W  = 21;
    localparam int MAX_EXP = 20;

    localparam logic [7:0] FRAME_HDR   = 8'hA5;
    localparam int         FRAME_LEN   = 18;
    localparam logic [7:0] EXP_INVALID = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START_BIT = 2'd1,
        S_DATA      = 2'd2,
        S_STOP_BIT  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/board_uart_tx_tile_log2.sv
// rtl/board_uart_tx_tile_log2.sv - combinational tile value to log2 exponent encoder
module tile_log2
    import game_pkg::*;
#(
    parameter int W = game_pkg::CELL_W
) (
    input  logic [W-1:0] i_cell,
    output logic [7:0]   o_exp,
    output logic         o_valid
);

    // Exact match against 2^1..2^MAX_EXP; empty cell encodes as 0; anything else is invalid.
    // Any bit above MAX_EXP can never match a power in range, so wide cells are rejected naturally.
    always_comb begin
        o_exp   = EXP_INVALID;
        o_valid = 1'b0;
        for (int k = 1; k <= MAX_EXP; k++) begin
            if (i_cell == (W'(1) << k)) begin
                o_exp   = 8'(k);
                o_valid = 1'b1;
            end
        end
        if (i_cell == '0) begin
            o_exp   = 8'h00;
            o_valid = 1'b1;
        end
    end

endmodule

// File: rtl/board_uart_tx.sv
// rtl/board_uart_tx.sv - snapshots the 4x4 board and sends it as an 18-byte UART 8N1 frame
module board_uart_tx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200,
    parameter int CELL_W   = game_pkg::CELL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [16*CELL_W-1:0] board_flat,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 tx
);

    import game_pkg::*;

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    tx_state_t        r_state;
    tx_state_t        w_state_next;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [CNT_W-1:0] w_baud_next;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_next;
    logic [4:0]       r_byte_idx;
    logic [4:0]       w_byte_next;
    logic             r_done;
    logic             w_done_next;
    logic             w_accept;
    logic             w_bit_end;

    logic [7:0]       r_snap [CELLS];
    logic [7:0]       r_csum;
    logic             r_err;

    logic [7:0]       w_exp [CELLS];
    logic [CELLS-1:0] w_valid;
    logic [7:0]       w_csum;
    logic [7:0]       w_cur_byte;
    logic [3:0]       w_snap_idx;

    // One encoder per cell so the whole board is snapshotted in the accept cycle.
    for (genvar g = 0; g < CELLS; g++) begin : g_tile
        tile_log2 #(.W(CELL_W)) u_tile (
            .i_cell  (board_flat[g*CELL_W +: CELL_W]),
            .o_exp   (w_exp[g]),
            .o_valid (w_valid[g])
        );
    end

    // Checksum over the freshly encoded payload, captured together with the snapshot.
    always_comb begin
        w_csum = 8'h00;
        for (int i = 0; i < CELLS; i++) begin
            w_csum = w_csum ^ w_exp[i];
        end
    end

    assign w_bit_end = (r_baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Next-state logic: start/data/stop bits each last CLKS_PER_BIT cycles, bytes run back-to-back.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = w_bit_end ? '0 : r_baud_cnt + CNT_W'(1);
        w_bit_next   = r_bit_idx;
        w_byte_next  = r_byte_idx;
        w_done_next  = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                w_bit_next  = 3'd0;
                w_byte_next = 5'd0;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_START_BIT;
                end
            end
            S_START_BIT: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_bit_next   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP_BIT;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP_BIT: begin
                if (w_bit_end) begin
                    if (r_byte_idx < 5'(FRAME_LEN - 1)) begin
                        w_byte_next  = r_byte_idx + 5'd1;
                        w_state_next = S_START_BIT;
                    end else begin
                        w_byte_next  = 5'd0;
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, bit timing counters and the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 5'd0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_idx  <= w_bit_next;
            r_byte_idx <= w_byte_next;
            r_done     <= w_done_next;
        end
    end

    // Snapshot, checksum and error flag are only loaded on an accepted start, so later board edits are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CELLS; i++) begin
                r_snap[i] <= 8'h00;
            end
            r_csum <= 8'h00;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_snap <= w_exp;
            r_csum <= w_csum;
            r_err  <= ~(&w_valid);
        end
    end

    assign w_snap_idx = 4'(r_byte_idx - 5'd1);

    // Byte currently on the wire: header, sixteen exponents, checksum.
    always_comb begin
        w_cur_byte = r_snap[w_snap_idx];
        if (r_byte_idx == 5'd0) begin
            w_cur_byte = FRAME_HDR;
        end else if (r_byte_idx == 5'(FRAME_LEN - 1)) begin
            w_cur_byte = r_csum;
        end
    end

    // Line level decoded from registered state, so an async reset returns it high at once.
    always_comb begin
        tx = 1'b1;
        case (r_state)
            S_START_BIT: tx = 1'b0;
            S_DATA:      tx = w_cur_byte[r_bit_idx];
            default:     tx = 1'b1;
        endcase
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_board_uart_tx.sv
// tb/tb_board_uart_tx.sv - self-checking bench for board_uart_tx
module tb_board_uart_tx;

    localparam int CLK_FREQ   = 16;
    localparam int BAUD       = 1;
    localparam int N          = CLK_FREQ / BAUD;
    localparam int CW         = 21;
    localparam int BW         = 16 * CW;
    localparam int FRAME_BITS = 180;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BW-1:0] board_flat;
    logic          busy;
    logic          done;
    logic          err;
    logic          tx;

    int errors = 0;
    int checks = 0;

    logic [7:0] last_bytes [18];
    logic       last_err;

    typedef struct {
        string         name;
        logic [BW-1:0] board;
        logic [7:0]    csum;
        logic          err;
    } vec_t;

    vec_t vecs [5];

    board_uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .CELL_W   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .board_flat (board_flat),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_exp(input logic [CW-1:0] v);
        if (v == '0) return 8'h00;
        if ($countones(v) == 1 && v != 1) return 8'($clog2(v));
        return 8'hFF;
    endfunction

    function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int idx, input logic [CW-1:0] v);
        b[idx*CW +: CW] = v;
        return b;
    endfunction

    function automatic logic [BW-1:0] rand_board();
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0:       b = put(b, i, '0);
                1, 2:    b = put(b, i, CW'(1) << $urandom_range(1, 20));
                default: b = put(b, i, CW'($urandom));
            endcase
        end
        return b;
    endfunction

    // Caller is positioned at a negedge; returns at the negedge where done must be high.
    task automatic run_frame(input logic [BW-1:0] board, input string name,
                             input bit repulse, input bit change_after);
        logic [7:0] expb [18];
        logic       exp_e;
        logic [7:0] cs;
        logic [7:0] e;
        logic       rxbits [FRAME_BITS];
        int         busy_bad;
        int         done_bad;
        int         framing_bad;
        logic [7:0] byt;

        expb[0] = 8'hA5;
        exp_e   = 1'b0;
        cs      = 8'h00;
        for (int i = 0; i < 16; i++) begin
            e = model_exp(board[i*CW +: CW]);
            expb[i+1] = e;
            cs = cs ^ e;
            if (e == 8'hFF) exp_e = 1'b1;
        end
        expb[17] = cs;

        board_flat = board;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (change_after) board_flat = ~board;
        check({name, " first tx low"}, tx, 0);
        check({name, " err at start"}, err, exp_e);

        busy_bad = 0;
        done_bad = 0;
        for (int c = 0; c < FRAME_BITS * N; c++) begin
            if (c != 0) @(negedge clk);
            start = repulse && (c == 100 || c == 1000);
            if (!busy) busy_bad++;
            if (done)  done_bad++;
            if (c % N == N / 2) rxbits[c / N] = tx;
        end
        @(negedge clk);
        start = 1'b0;
        check({name, " busy held"}, busy_bad, 0);
        check({name, " no early done"}, done_bad, 0);
        check({name, " done at 180 bits"}, done, 1);
        check({name, " busy low at done"}, busy, 0);
        check({name, " tx idle at done"}, tx, 1);
        check({name, " err at done"}, err, exp_e);

        framing_bad = 0;
        for (int j = 0; j < 18; j++) begin
            if (rxbits[j*10] !== 1'b0 || rxbits[j*10+9] !== 1'b1) framing_bad++;
            for (int k = 0; k < 8; k++) byt[k] = rxbits[j*10+1+k];
            last_bytes[j] = byt;
            check($sformatf("%s byte%0d", name, j), byt, expb[j]);
        end
        check({name, " framing"}, framing_bad, 0);
        last_err = err;
    endtask

    initial begin
        logic [BW-1:0] b;

        rst        = 1'b0;
        start      = 1'b0;
        board_flat = '0;
        repeat (3) @(negedge clk);
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        rst = 1'b1;
        @(negedge clk);

        vecs[0] = '{"zero", '0, 8'h00, 1'b0};
        b = put('0, 0, 21'd2);
        b = put(b, 5, 21'd2048);
        b = put(b, 15, 21'd4);
        vecs[1] = '{"mixed", b, 8'h08, 1'b0};
        vecs[2] = '{"bad6", put('0, 3, 21'd6), 8'hFF, 1'b1};
        b = put('0, 7, 21'h100000);
        b = put(b, 8, 21'd1);
        vecs[3] = '{"max_and_one", b, 8'hEB, 1'b1};
        b = '0;
        for (int i = 0; i < 16; i++) b = put(b, i, CW'(1) << (i + 1));
        vecs[4] = '{"ramp", b, 8'h10, 1'b0};

        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].board, vecs[v].name, 1'b0, 1'b0);
            check({vecs[v].name, " table csum"}, last_bytes[17], vecs[v].csum);
            check({vecs[v].name, " table err"}, last_err, vecs[v].err);
            @(negedge clk);
            check({vecs[v].name, " done one cycle"}, done, 0);
        end
        check("bad6 byte4 invalid", 32'(vecs[2].csum), 32'hFF);

        run_frame(rand_board(), "repulse", 1'b1, 1'b0);
        @(negedge clk);
        check("repulse single done", done, 0);
        check("repulse idle", busy, 0);

        run_frame(vecs[1].board, "snapshot", 1'b0, 1'b1);
        @(negedge clk);

        // Reset in the middle of a frame, while tx is low in a data bit.
        b = put(vecs[2].board, 2, 21'd4);
        board_flat = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (500) @(negedge clk);
        check("pre-reset tx low", tx, 0);
        check("pre-reset err", err, 1);
        #1 rst = 1'b0;
        #1;
        check("async reset tx", tx, 1);
        check("async reset busy", busy, 0);
        check("async reset err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post-reset idle tx", tx, 1);
        run_frame(vecs[4].board, "after_reset", 1'b0, 1'b0);

        // Random boards; odd iterations start in the done cycle of the previous frame.
        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 0) @(negedge clk);
            run_frame(rand_board(), $sformatf("rand%0d", r), 1'b0, 1'b0);
        end
        @(negedge clk);
        check("final idle busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
